// File: rtl/rx_frame_asm.sv
// Receive frame assembler: parses src/dst/len/payload/crc bytes from the deserializer,
// filters on destination, checks CRC residue and stores header+payload into a 256-byte buffer.
module rx_frame_asm #(
    parameter int          MAX_LEN    = 253,
    parameter logic [7:0]  BCAST_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_idle,
    input  logic [7:0]  data,
    input  logic        data_clk,
    input  logic [15:0] crc_data,
    input  logic [7:0]  filter,
    input  logic        promisc,
    input  logic        buf_free,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic [8:0]  frame_len,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_break,
    output logic        lost
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CRC, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  len_q, len_d;
    logic        crc_cnt_q, crc_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic [8:0]  frame_len_q, frame_len_d;
    logic        err_crc_q, err_crc_d;
    logic        err_len_q, err_len_d;
    logic        err_break_q, err_break_d;
    logic        lost_q, lost_d;

    logic dst_match;
    assign dst_match = promisc || (data == filter) || (data == BCAST_ADDR);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        crc_cnt_d   = crc_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        frame_len_d = frame_len_q;
        err_crc_d   = 1'b0;
        err_len_d   = 1'b0;
        err_break_d = 1'b0;
        lost_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_clk && !bus_idle) begin
                    if (buf_free) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = 8'd0;
                        wr_data_d  = data;
                        byte_cnt_d = 8'd1;
                        state_d    = S_HDR;
                    end else begin
                        lost_d  = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_HDR, S_DATA, S_CRC: begin
                // A bus break wins over a byte arriving in the same cycle.
                if (bus_idle) begin
                    err_break_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (data_clk) begin
                    if (state_q == S_HDR && byte_cnt_q == 8'd1) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = 8'd1;
                        wr_data_d = data;
                        if (dst_match) begin
                            byte_cnt_d = 8'd2;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (state_q == S_HDR) begin
                        if ({1'b0, data} > 9'(MAX_LEN)) begin
                            err_len_d = 1'b1;
                            state_d   = S_DROP;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = 8'd2;
                            wr_data_d  = data;
                            len_d      = data;
                            byte_cnt_d = 8'd3;
                            crc_cnt_d  = 1'b0;
                            state_d    = (data == 8'd0) ? S_CRC : S_DATA;
                        end
                    end else if (state_q == S_DATA) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = byte_cnt_q;
                        wr_data_d  = data;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        // Last payload byte lands at len+2, at most 255.
                        if (byte_cnt_q == len_q + 8'd2) begin
                            crc_cnt_d = 1'b0;
                            state_d   = S_CRC;
                        end
                    end else begin
                        if (!crc_cnt_q) begin
                            crc_cnt_d = 1'b1;
                        end else begin
                            if (crc_data == 16'h0000) begin
                                done_d      = 1'b1;
                                frame_len_d = {1'b0, len_q} + 9'd3;
                            end else begin
                                err_crc_d = 1'b1;
                            end
                            state_d = S_DROP;
                        end
                    end
                end
            end
            S_DROP: begin
                if (bus_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_DROP;
            byte_cnt_q  <= 8'd0;
            len_q       <= 8'd0;
            crc_cnt_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            done_q      <= 1'b0;
            frame_len_q <= 9'd0;
            err_crc_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_break_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            crc_cnt_q   <= crc_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            frame_len_q <= frame_len_d;
            err_crc_q   <= err_crc_d;
            err_len_q   <= err_len_d;
            err_break_q <= err_break_d;
            lost_q      <= lost_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_len  = frame_len_q;
    assign err_crc    = err_crc_q;
    assign err_len    = err_len_q;
    assign err_break  = err_break_q;
    assign lost       = lost_q;

endmodule
